// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory-access stage. Runs req/ack data-memory
//               transactions with timeout, stalls the front end meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int DMEM_ADDR_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES         = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              ex_valid_i,
  input  logic                              mem_read_i,
  input  logic                              mem_write_i,
  input  logic                              reg_write_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        store_data_i,
  output logic                              dmem_req_o,
  output logic                              dmem_we_o,
  output logic [DMEM_ADDR_WIDTH-1:0]        dmem_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_wdata_o,
  input  logic                              dmem_ack_i,
  input  logic [PROC_DATA_WIDTH-1:0]        dmem_rdata_i,
  output logic                              stall_o,
  output logic                              reg_write_en_o,
  output logic                              mem_to_reg_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        alu_o,
  output logic [PROC_DATA_WIDTH-1:0]        mem_data_o,
  output logic                              bus_err_o,
  output logic                              bus_err_sticky_o
);

  localparam int                   C_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_MAX  = C_CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic [C_CNT_W-1:0]                r_cnt;
  logic                              r_reg_write_en;
  logic                              r_mem_to_reg;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] r_reg_write_addr;
  logic [PROC_DATA_WIDTH-1:0]        r_alu;
  logic                              w_access;
  logic                              w_last_busy;

  assign w_access    = ex_valid_i & (mem_read_i | mem_write_i);
  assign w_last_busy = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    stall_o          = 1'b0;
    reg_write_en_o   = ex_valid_i & reg_write_en_i;
    mem_to_reg_o     = mem_to_reg_i;
    reg_write_addr_o = reg_write_addr_i;
    alu_o            = alu_i;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_state_next   = S_BUSY;
          stall_o        = 1'b1;
          reg_write_en_o = 1'b0;
          mem_to_reg_o   = 1'b0;
        end
      end
      S_BUSY: begin
        stall_o          = 1'b1;
        reg_write_en_o   = 1'b0;
        mem_to_reg_o     = 1'b0;
        reg_write_addr_o = r_reg_write_addr;
        alu_o            = r_alu;
        // An ack on the last permitted cycle still wins over the timeout.
        if (dmem_ack_i || w_last_busy) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next     = S_IDLE;
        reg_write_en_o   = r_reg_write_en & ~dmem_we_o;
        mem_to_reg_o     = r_mem_to_reg;
        reg_write_addr_o = r_reg_write_addr;
        alu_o            = r_alu;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (!rst_i) begin
      stall_o        = 1'b0;
      reg_write_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt            <= '0;
      r_reg_write_en   <= 1'b0;
      r_mem_to_reg     <= 1'b0;
      r_reg_write_addr <= '0;
      r_alu            <= '0;
      dmem_req_o       <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_wdata_o     <= '0;
      mem_data_o       <= '0;
      bus_err_o        <= 1'b0;
      bus_err_sticky_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_cnt            <= '0;
            r_reg_write_en   <= reg_write_en_i;
            r_mem_to_reg     <= mem_to_reg_i;
            r_reg_write_addr <= reg_write_addr_i;
            r_alu            <= alu_i;
            dmem_req_o       <= 1'b1;
            dmem_we_o        <= mem_write_i;
            dmem_addr_o      <= alu_i[DMEM_ADDR_WIDTH-1:0];
            dmem_wdata_o     <= store_data_i;
          end
        end
        S_BUSY: begin
          if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) begin
              mem_data_o <= dmem_rdata_i;
            end
          end else if (w_last_busy) begin
            dmem_req_o       <= 1'b0;
            mem_data_o       <= '0;
            bus_err_o        <= 1'b1;
            bus_err_sticky_o <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench: vector table plus scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, mem_read_i, mem_write_i, reg_write_en_i, mem_to_reg_i;
  logic [4:0]  reg_write_addr_i;
  logic [15:0] alu_i, store_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [7:0]  dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [15:0] dmem_rdata_i;
  logic        stall_o, reg_write_en_o, mem_to_reg_o;
  logic [4:0]  reg_write_addr_o;
  logic [15:0] alu_o, mem_data_o;
  logic        bus_err_o, bus_err_sticky_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(
    .PROC_DATA_WIDTH(16), .PROC_REGFILE_LOG2_DEEP(5),
    .DMEM_ADDR_WIDTH(8), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .reg_write_en_i(reg_write_en_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_addr_i(reg_write_addr_i), .alu_i(alu_i), .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .reg_write_en_o(reg_write_en_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_addr_o(reg_write_addr_o), .alu_o(alu_o), .mem_data_o(mem_data_o),
    .bus_err_o(bus_err_o), .bus_err_sticky_o(bus_err_sticky_o)
  );

  typedef struct {
    // stimulus
    logic        ev, rd, wr, rwe, m2r;
    logic [4:0]  rdst;
    logic [15:0] alu, sdata, rdata;
    int          ack_cycle;     // 0 = never ack
    // expected
    int          e_stall, e_reqs;
    logic        e_we;
    logic [7:0]  e_addr;
    logic        e_rwe, e_m2r;
    logic [15:0] e_mdata;
    logic        e_err, e_sticky;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    reg_write_en_i = 1'b0; mem_to_reg_i = 1'b0; reg_write_addr_i = 5'd0;
    alu_i = 16'h0; store_data_i = 16'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   stall_cnt, req_cnt;
    bit   done;
    @(negedge clk_i);
    ex_valid_i = v.ev; mem_read_i = v.rd; mem_write_i = v.wr;
    reg_write_en_i = v.rwe; mem_to_reg_i = v.m2r; reg_write_addr_i = v.rdst;
    alu_i = v.alu; store_data_i = v.sdata;
    sb.push_back(v);
    #1;
    stall_cnt = 0; req_cnt = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall_o) begin
        stall_cnt++;
        if (dmem_req_o) begin
          req_cnt++;
          chk($sformatf("v%0d addr", idx), {24'd0, dmem_addr_o}, {24'd0, v.e_addr});
          chk($sformatf("v%0d we", idx), {31'd0, dmem_we_o}, {31'd0, v.e_we});
          if (v.e_we)
            chk($sformatf("v%0d wdata", idx), {16'd0, dmem_wdata_o}, {16'd0, v.sdata});
          if (req_cnt == v.ack_cycle) begin
            dmem_ack_i = 1'b1; dmem_rdata_i = v.rdata;
          end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
        #1;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL v%0d stall never released after 40 cycles", idx);
    end
    e = sb.pop_front();
    chk($sformatf("v%0d stall_cycles", idx), stall_cnt, e.e_stall);
    chk($sformatf("v%0d req_cycles", idx), req_cnt, e.e_reqs);
    chk($sformatf("v%0d reg_write_en_o", idx), {31'd0, reg_write_en_o}, {31'd0, e.e_rwe});
    chk($sformatf("v%0d mem_to_reg_o", idx), {31'd0, mem_to_reg_o}, {31'd0, e.e_m2r});
    chk($sformatf("v%0d reg_write_addr_o", idx), {27'd0, reg_write_addr_o}, {27'd0, e.rdst});
    chk($sformatf("v%0d alu_o", idx), {16'd0, alu_o}, {16'd0, e.alu});
    chk($sformatf("v%0d mem_data_o", idx), {16'd0, mem_data_o}, {16'd0, e.e_mdata});
    chk($sformatf("v%0d bus_err_o", idx), {31'd0, bus_err_o}, {31'd0, e.e_err});
    chk($sformatf("v%0d bus_err_sticky_o", idx), {31'd0, bus_err_sticky_o}, {31'd0, e.e_sticky});
    // Instruction leaves EX/MEM; the error pulse must not persist.
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk($sformatf("v%0d post stall_o", idx), {31'd0, stall_o}, 32'd0);
    chk($sformatf("v%0d post bus_err_o", idx), {31'd0, bus_err_o}, 32'd0);
  endtask

  initial begin
    //            ev rd wr rwe m2r rdst alu       sdata     rdata     ack  stall reqs we addr   rwe m2r mdata    err stk
    vecs[0] = '{1, 0, 0, 1, 0, 5'd3,  16'h1234, 16'h0000, 16'h0000, 0,  0,  0,  0, 8'h00, 1, 0, 16'h0000, 0, 0};
    vecs[1] = '{1, 1, 0, 1, 1, 5'd5,  16'h01A5, 16'h1111, 16'hBEEF, 1,  2,  1,  0, 8'hA5, 1, 1, 16'hBEEF, 0, 0};
    vecs[2] = '{1, 1, 1, 1, 0, 5'd7,  16'h0042, 16'h5A5A, 16'h9999, 3,  4,  3,  1, 8'h42, 0, 0, 16'hBEEF, 0, 0};
    vecs[3] = '{0, 1, 0, 1, 1, 5'd9,  16'h0077, 16'h0000, 16'h0000, 0,  0,  0,  0, 8'h00, 0, 1, 16'hBEEF, 0, 0};
    vecs[4] = '{1, 1, 0, 1, 1, 5'd10, 16'h0310, 16'h0000, 16'hAAAA, 0, 16, 15,  0, 8'h10, 1, 1, 16'h0000, 1, 1};
    vecs[5] = '{1, 1, 0, 1, 1, 5'd11, 16'hFF80, 16'h0000, 16'h1357, 15, 16, 15, 0, 8'h80, 1, 1, 16'h1357, 0, 1};
    vecs[6] = '{1, 0, 0, 0, 0, 5'd2,  16'hABCD, 16'h0000, 16'h0000, 0,  0,  0,  0, 8'h00, 0, 0, 16'h1357, 0, 1};
    vecs[7] = '{1, 0, 1, 1, 0, 5'd4,  16'h0055, 16'hC3C3, 16'h0000, 0, 16, 15,  1, 8'h55, 0, 0, 16'h0000, 1, 1};

    rst_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
    idle_inputs();
    ex_valid_i = 1'b1; reg_write_en_i = 1'b1; mem_read_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst dmem_req_o", {31'd0, dmem_req_o}, 32'd0);
    chk("rst dmem_we_o", {31'd0, dmem_we_o}, 32'd0);
    chk("rst dmem_addr_o", {24'd0, dmem_addr_o}, 32'd0);
    chk("rst dmem_wdata_o", {16'd0, dmem_wdata_o}, 32'd0);
    chk("rst mem_data_o", {16'd0, mem_data_o}, 32'd0);
    chk("rst bus_err_o", {31'd0, bus_err_o}, 32'd0);
    chk("rst bus_err_sticky_o", {31'd0, bus_err_sticky_o}, 32'd0);
    chk("rst stall_o", {31'd0, stall_o}, 32'd0);
    chk("rst reg_write_en_o", {31'd0, reg_write_en_o}, 32'd0);
    idle_inputs();
    rst_i = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during BUSY cycle 2 drops the request and clears sticky.
    @(negedge clk_i);
    ex_valid_i = 1'b1; mem_read_i = 1'b1; reg_write_en_i = 1'b1; alu_i = 16'h0021;
    #1;
    chk("rstbusy accept stall_o", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    chk("rstbusy cycle1 req", {31'd0, dmem_req_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rstbusy stall_o in reset", {31'd0, stall_o}, 32'd0);
    chk("rstbusy reg_write_en_o in reset", {31'd0, reg_write_en_o}, 32'd0);
    @(negedge clk_i);
    chk("rstbusy dmem_req_o", {31'd0, dmem_req_o}, 32'd0);
    chk("rstbusy bus_err_sticky_o", {31'd0, bus_err_sticky_o}, 32'd0);
    rst_i = 1'b1;
    idle_inputs();
    #1;
    chk("rstbusy idle stall_o", {31'd0, stall_o}, 32'd0);

    // Spurious ack in IDLE.
    dmem_ack_i = 1'b1; dmem_rdata_i = 16'hDEAD;
    @(negedge clk_i);
    dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
    #1;
    chk("spurious mem_data_o", {16'd0, mem_data_o}, 32'd0);
    chk("spurious dmem_req_o", {31'd0, dmem_req_o}, 32'd0);
    chk("spurious stall_o", {31'd0, stall_o}, 32'd0);
    chk("spurious bus_err_o", {31'd0, bus_err_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
